counter_trigger_generator: RTL and testbench

Produces the counter_trigger level consumed by the reset manager's internal-trigger path, which ANDs it with the internal-trigger enable cfg bit. After the processor arms it, the block waits until a free-running sample counter equals a programmed reference value, waits a programmable delay, then raises counter_trigger. The trigger stays high until the trigger is reset or disabled. When disabled, counter_trigger is held high so the downstream AND reduces to the enable bit alone.

---
 rtl/counter_trigger_generator.sv | 121 ++++++++++++
 tb/tb_counter_trigger_generator.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/counter_trigger_generator.sv
// Counter-match trigger generator for the reset manager's internal-trigger path.
// Arms on request, waits for a counter match plus delay, then raises a held trigger.
module counter_trigger_generator #(
  parameter int COUNTER_WIDTH    = 32,
  parameter int TRIG_COUNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     aresetn,
  input  logic                     enable,
  input  logic                     arm,
  input  logic                     trigger_reset,
  input  logic [COUNTER_WIDTH-1:0] sample_counter,
  input  logic [COUNTER_WIDTH-1:0] reference,
  input  logic [COUNTER_WIDTH-1:0] delay,
  output logic                     counter_trigger,
  output logic [31:0]              sts
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_ARM,
    ARMED,
    DELAY,
    TRIGGERED
  } state_t;

  localparam logic [COUNTER_WIDTH-1:0]    DLY_ONE = 1;
  localparam logic [TRIG_COUNT_WIDTH-1:0] CNT_ONE = 1;

  state_t                      state_q, state_d;
  logic                        trig_q, trig_d;
  logic [COUNTER_WIDTH-1:0]    dly_q, dly_d;
  logic [TRIG_COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                        arm_q, reset_q;

  logic arm_rise, rst_rise, match;

  assign arm_rise = arm & ~arm_q;
  assign rst_rise = trigger_reset & ~reset_q;
  assign match    = (sample_counter == reference);

  // Next state: disable beats disarm beats local progress.
  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    cnt_d   = cnt_q;
    trig_d  = trig_q;
    if (!enable) begin
      state_d = IDLE;
    end else if (rst_rise &&
                 (state_q == ARMED || state_q == DELAY ||
                  state_q == TRIGGERED)) begin
      state_d = WAIT_ARM;
    end else begin
      unique case (state_q)
        IDLE: state_d = WAIT_ARM;
        WAIT_ARM: begin
          if (arm_rise && !rst_rise) state_d = ARMED;
        end
        ARMED: begin
          if (match) begin
            if (delay != '0) begin
              state_d = DELAY;
              dly_d   = delay - DLY_ONE;
            end else begin
              state_d = TRIGGERED;
            end
          end
        end
        DELAY: begin
          if (dly_q == '0) state_d = TRIGGERED;
          else             dly_d   = dly_q - DLY_ONE;
        end
        TRIGGERED: state_d = TRIGGERED;
        default:   state_d = IDLE;
      endcase
    end
    if (state_d == TRIGGERED && state_q != TRIGGERED)
      cnt_d = cnt_q + CNT_ONE;
    trig_d = (state_d == IDLE) || (state_d == TRIGGERED);
  end

  // State, delay counter, event counter and trigger level.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_q <= IDLE;
      trig_q  <= 1'b1;
      dly_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      trig_q  <= trig_d;
      dly_q   <= dly_d;
      cnt_q   <= cnt_d;
    end
  end

  // Previous values of the request inputs for edge detection.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      arm_q   <= 1'b0;
      reset_q <= 1'b0;
    end else begin
      arm_q   <= arm;
      reset_q <= trigger_reset;
    end
  end

  assign counter_trigger = trig_q;

  // Status word assembled from registered state.
  always_comb begin
    sts = '0;
    sts[0] = enable;
    sts[1] = (state_q == ARMED);
    sts[2] = (state_q == DELAY);
    sts[3] = (state_q == TRIGGERED);
    sts[16 +: TRIG_COUNT_WIDTH] = cnt_q;
  end

endmodule

// File: tb/tb_counter_trigger_generator.sv
// Directed bench for counter_trigger_generator.
// Inputs change 1ns after each rising edge; outputs are checked there too.
module tb_counter_trigger_generator;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        enable;
  logic        arm;
  logic        trigger_reset;
  logic [31:0] sc;
  logic [31:0] reference;
  logic [31:0] delay;
  logic        counter_trigger;
  logic [31:0] sts;

  int n_run  = 0;
  int n_fail = 0;

  counter_trigger_generator #(
    .COUNTER_WIDTH(32),
    .TRIG_COUNT_WIDTH(16)
  ) dut (
    .clk(clk),
    .aresetn(aresetn),
    .enable(enable),
    .arm(arm),
    .trigger_reset(trigger_reset),
    .sample_counter(sc),
    .reference(reference),
    .delay(delay),
    .counter_trigger(counter_trigger),
    .sts(sts)
  );

  always #4 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    sc = sc + 32'd1;
  endtask

  task automatic pulse_reset();
    trigger_reset = 1'b1;
    tick();
    trigger_reset = 1'b0;
  endtask

  initial begin
    aresetn       = 1'b0;
    enable        = 1'b0;
    arm           = 1'b0;
    trigger_reset = 1'b0;
    sc            = 32'd0;
    reference     = 32'hFFFF_0000;
    delay         = 32'd0;

    // Reset and idle
    repeat (4) tick();
    chk("rst_trig", {31'd0, counter_trigger}, 32'd1);
    chk("rst_sts", sts, 32'h0000_0000);
    aresetn = 1'b1;
    tick();
    chk("idle_trig", {31'd0, counter_trigger}, 32'd1);
    enable = 1'b1;
    tick();
    chk("en_trig", {31'd0, counter_trigger}, 32'd0);
    chk("en_sts", sts, 32'h0000_0001);

    // Basic trigger, delay 0
    reference = 32'd1000;
    delay     = 32'd0;
    sc        = 32'd500;
    arm       = 1'b1;
    tick();
    arm = 1'b0;
    chk("armed_sts", sts, 32'h0000_0003);
    repeat (499) tick();
    chk("pre_match_trig", {31'd0, counter_trigger}, 32'd0);
    chk("pre_match_sts", sts, 32'h0000_0003);
    tick();
    chk("basic_trig", {31'd0, counter_trigger}, 32'd1);
    chk("basic_sts", sts, 32'h0001_0009);
    reference = 32'd2000;
    tick();
    chk("hold_trig", {31'd0, counter_trigger}, 32'd1);

    // Reset and re-arm
    pulse_reset();
    chk("disarm_trig", {31'd0, counter_trigger}, 32'd0);
    chk("disarm_sts", sts, 32'h0001_0001);
    reference = sc + 32'd3;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    tick();
    tick();
    chk("rearm_wait_sts", sts, 32'h0001_0003);
    tick();
    chk("rearm_trig", {31'd0, counter_trigger}, 32'd1);
    chk("rearm_sts", sts, 32'h0002_0009);

    // Simultaneous arm and reset in WAIT_ARM; arm while ARMED
    pulse_reset();
    tick();
    arm = 1'b1;
    trigger_reset = 1'b1;
    tick();
    arm = 1'b0;
    trigger_reset = 1'b0;
    chk("simul_sts", sts, 32'h0002_0001);
    chk("simul_trig", {31'd0, counter_trigger}, 32'd0);
    tick();
    reference = sc + 32'd100;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    tick();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    chk("arm_ignored_sts", sts, 32'h0002_0003);
    pulse_reset();
    chk("armed_reset_sts", sts, 32'h0002_0001);
    tick();

    // Delay with wrap-around; delay changed mid-DELAY
    sc        = 32'hFFFF_FFF0;
    reference = 32'd5;
    delay     = 32'd10;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    repeat (20) tick();
    chk("wrap_armed_sts", sts, 32'h0002_0003);
    tick();
    chk("delay_sts", sts, 32'h0002_0005);
    delay = 32'd3;
    repeat (9) tick();
    chk("delay_end_trig", {31'd0, counter_trigger}, 32'd0);
    chk("delay_end_sts", sts, 32'h0002_0005);
    tick();
    chk("delay_trig", {31'd0, counter_trigger}, 32'd1);
    chk("delay_trig_sts", sts, 32'h0003_0009);

    // Disable during DELAY
    pulse_reset();
    reference = sc + 32'd1;
    delay     = 32'd5;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    tick();
    chk("dis_pre_sts", sts, 32'h0003_0005);
    tick();
    enable = 1'b0;
    tick();
    chk("dis_trig", {31'd0, counter_trigger}, 32'd1);
    chk("dis_sts", sts, 32'h0003_0000);
    enable = 1'b1;
    tick();
    chk("reen_trig", {31'd0, counter_trigger}, 32'd0);

    // aresetn while TRIGGERED clears the event count
    reference = sc + 32'd1;
    delay     = 32'd0;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    tick();
    chk("cnt4_sts", sts, 32'h0004_0009);
    aresetn = 1'b0;
    tick();
    chk("hard_rst_trig", {31'd0, counter_trigger}, 32'd1);
    chk("hard_rst_sts", sts, 32'h0000_0001);
    aresetn = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
